branch_resolve: RTL

- Execute-stage branch resolution unit in the RISC-V core; consumes the flags of the branch comparator (brlt, breq) and drives its unsigned-select input.
- Decides taken/not-taken from funct3 and compares the decision with the fetch-time prediction to raise mispredict.
- Owns a direct-mapped table of 2-bit saturating counters: read at fetch for prediction, updated at resolution.
- Keeps branch and mispredict performance counters for CSR readout.

---
 rtl/branch_resolve.sv | 106 ++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: funct3 decode, mispredict detection,
// a direct-mapped 2-bit saturating-counter predictor, and perf counters.

module bp_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic       taken,
  output logic [1:0] st
);
  always_ff @(posedge clk) begin
    if (rst)
      st <= 2'b01;
    else if (upd) begin
      if (taken && st != 2'b11)
        st <= st + 2'd1;
      else if (!taken && st != 2'b00)
        st <= st - 2'd1;
    end
  end
endmodule

module branch_resolve #(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] pc_fetch,
  output logic        pred_taken,
  input  logic [31:0] pc_ex,
  input  logic        is_br_ex,
  input  logic [2:0]  funct3,
  input  logic        pred_taken_ex,
  input  logic        brlt,
  input  logic        breq,
  output logic        brun,
  output logic        br_taken,
  output logic        mispredict,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);
  logic [ENTRIES-1:0][1:0] tbl;
  logic [ENTRIES-1:0]      upd_vec;
  logic [IDX_W-1:0]        fidx, eidx;
  logic                    legal, taken_raw, upd;
  logic [31:0]             br_count_nxt, mispred_count_nxt;
  logic                    unused_pc;

  assign fidx = pc_fetch[IDX_W+1:2];
  assign eidx = pc_ex[IDX_W+1:2];
  assign unused_pc = ^{pc_fetch[31:IDX_W+2], pc_fetch[1:0],
                       pc_ex[31:IDX_W+2], pc_ex[1:0]};

  // 010/011 are reserved encodings in the branch opcode space
  assign legal = !(funct3[2:1] == 2'b01);
  assign brun  = funct3[1];

  always_comb begin
    taken_raw = 1'b0;
    case (funct3)
      3'b000:          taken_raw = breq;
      3'b001:          taken_raw = !breq;
      3'b100, 3'b110:  taken_raw = brlt;
      3'b101, 3'b111:  taken_raw = !brlt;
      default:         taken_raw = 1'b0;
    endcase
  end

  assign br_taken   = is_br_ex & legal & taken_raw;
  assign mispredict = is_br_ex & legal & (br_taken != pred_taken_ex);
  assign upd        = is_br_ex & legal & !stall;

  // Lookup reads the registered table, so a same-index update is not bypassed
  assign pred_taken = tbl[fidx][1];

  genvar g;
  generate
    for (g = 0; g < ENTRIES; g++) begin : g_ent
      assign upd_vec[g] = upd && (eidx == IDX_W'(g));
      bp_ctr u_ctr (
        .clk   (clk),
        .rst   (rst),
        .upd   (upd_vec[g]),
        .taken (br_taken),
        .st    (tbl[g])
      );
    end
  endgenerate

  // Free-running 32-bit counters; wrap is intentional
  assign br_count_nxt      = br_count + 32'd1;
  assign mispred_count_nxt = mispred_count + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count      <= 32'd0;
      mispred_count <= 32'd0;
    end else if (upd) begin
      br_count <= br_count_nxt;
      if (mispredict)
        mispred_count <= mispred_count_nxt;
    end
  end
endmodule
